// File: rtl/div_unit_pkg.sv
// Shared encodings for the execute-stage iterative divider.
// State codes, handshake levels and reset polarity used by div_unit.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic RstEnable         = 1'b1;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// short path for divide-by-zero, abortable by annul_i while iterating.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   localparam logic [5:0]       CntDone = 6'(WIDTH);
   localparam logic [WIDTH-1:0] One     = WIDTH'(1);

   div_state_e           r_state, w_state_next;
   logic [5:0]           r_cnt, w_cnt_next;
   logic [2*WIDTH:0]     r_dividend, w_dividend_next;
   logic [WIDTH-1:0]     r_divisor, w_divisor_next;
   logic                 r_op1_neg, w_op1_neg_next;
   logic                 r_op2_neg, w_op2_neg_next;
   logic                 r_signed, w_signed_next;
   logic                 r_ready, w_ready_next;
   logic [2*WIDTH-1:0]   r_result, w_result_next;

   logic [WIDTH-1:0]     w_op1_abs, w_op2_abs;
   logic [WIDTH:0]       w_diff;
   logic [WIDTH-1:0]     w_quot, w_rem, w_quot_fix, w_rem_fix;
   logic                 w_op2_zero;

   // Magnitudes only for signed operations; DIVU passes operands through.
   assign w_op1_abs  = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + One) : opdata1_i;
   assign w_op2_abs  = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + One) : opdata2_i;
   assign w_op2_zero = (opdata2_i == WIDTH'(ZeroWord));

   // Trial subtraction of the divisor from the current partial remainder.
   assign w_diff = {1'b0, r_dividend[2*WIDTH-1:WIDTH]} - {1'b0, r_divisor};

   assign w_quot     = r_dividend[WIDTH-1:0];
   assign w_rem      = r_dividend[2*WIDTH:WIDTH+1];
   assign w_quot_fix = (r_signed && (r_op1_neg ^ r_op2_neg)) ? (~w_quot + One) : w_quot;
   assign w_rem_fix  = (r_signed && r_op1_neg) ? (~w_rem + One) : w_rem;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_state    <= DivFree;
         r_cnt      <= '0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_op1_neg  <= 1'b0;
         r_op2_neg  <= 1'b0;
         r_signed   <= 1'b0;
         r_ready    <= DivResultNotReady;
         r_result   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_dividend <= w_dividend_next;
         r_divisor  <= w_divisor_next;
         r_op1_neg  <= w_op1_neg_next;
         r_op2_neg  <= w_op2_neg_next;
         r_signed   <= w_signed_next;
         r_ready    <= w_ready_next;
         r_result   <= w_result_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_dividend_next = r_dividend;
      w_divisor_next  = r_divisor;
      w_op1_neg_next  = r_op1_neg;
      w_op2_neg_next  = r_op2_neg;
      w_signed_next   = r_signed;
      w_ready_next    = r_ready;
      w_result_next   = r_result;

      case (r_state)
         DivFree: begin
            w_ready_next  = DivResultNotReady;
            w_result_next = '0;
            if (start_i == DivStart && !annul_i) begin
               if (w_op2_zero) begin
                  w_state_next = DivByZero;
               end else begin
                  w_state_next    = DivOn;
                  w_cnt_next      = '0;
                  w_dividend_next = {{WIDTH{1'b0}}, w_op1_abs, 1'b0};
                  w_divisor_next  = w_op2_abs;
                  w_op1_neg_next  = opdata1_i[WIDTH-1];
                  w_op2_neg_next  = opdata2_i[WIDTH-1];
                  w_signed_next   = signed_div_i;
               end
            end
         end

         DivByZero: begin
            w_dividend_next = '0;
            w_state_next    = DivEnd;
         end

         DivOn: begin
            if (annul_i) begin
               w_state_next  = DivFree;
               w_cnt_next    = '0;
               w_ready_next  = DivResultNotReady;
               w_result_next = '0;
            end else if (r_cnt != CntDone) begin
               if (w_diff[WIDTH]) begin
                  w_dividend_next = {r_dividend[2*WIDTH-1:0], 1'b0};
               end else begin
                  w_dividend_next = {w_diff[WIDTH-1:0], r_dividend[WIDTH-1:0], 1'b1};
               end
               w_cnt_next = r_cnt + 6'd1;
            end else begin
               // Sign fixup is folded back into the working register so END can replay it.
               w_dividend_next = {w_rem_fix, r_dividend[WIDTH], w_quot_fix};
               w_result_next   = {w_rem_fix, w_quot_fix};
               w_ready_next    = DivResultReady;
               w_state_next    = DivEnd;
               w_cnt_next      = '0;
            end
         end

         DivEnd: begin
            w_ready_next  = DivResultReady;
            w_result_next = {r_dividend[2*WIDTH:WIDTH+1], r_dividend[WIDTH-1:0]};
            if (start_i == DivStop) begin
               w_state_next  = DivFree;
               w_ready_next  = DivResultNotReady;
               w_result_next = '0;
            end
         end

         default: begin
            w_state_next = DivFree;
         end
      endcase
   end

   assign ready_o  = r_ready;
   assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic/latency reference model,
// per-cycle output comparison, directed corner cases and random operands.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1, op2;
   logic        start, annul;
   logic [63:0] result;
   logic        ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   // Architectural result {remainder, quotient}; division truncates toward zero.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      logic [31:0] qq, rr;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         qq = q[31:0];
         rr = r[31:0];
      end else begin
         qq = a / b;
         rr = a % b;
      end
      return {rr, qq};
   endfunction

   // Transaction-level model: an accepted request completes a fixed number of
   // edges later and is then held until start drops.
   logic [63:0] exp_result = 64'd0;
   logic        exp_ready  = 1'b0;
   bit          m_busy = 0, m_done = 0, m_zero = 0;
   int          m_left = 0;
   logic [63:0] m_res  = 64'd0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; exp_ready = 1'b0; exp_result = 64'd0;
      end else if (m_done) begin
         if (!start) begin
            m_done = 0; exp_ready = 1'b0; exp_result = 64'd0;
         end
      end else if (m_busy) begin
         if (annul && !m_zero) begin
            m_busy = 0; exp_ready = 1'b0; exp_result = 64'd0;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; exp_ready = 1'b1; exp_result = m_res;
            end
         end
      end else if (start && !annul) begin
         m_busy = 1;
         m_zero = (op2 == 32'd0);
         m_left = m_zero ? 2 : 33;
         m_res  = ref_div(op1, op2, signed_div);
      end
   end

   always @(negedge clk) begin
      checks++;
      if (ready !== exp_ready || result !== exp_result) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t: got ready=%b result=%h, expected ready=%b result=%h",
                  $time, ready, result, exp_ready, exp_result);
      end
   end

   task automatic pin(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // One division: start held until ready, held one extra cycle, then released.
   // lat counts edges including the one that samples start.
   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit chk_lit, input logic [63:0] lit);
      int  n;
      int  lat;
      bit  seen;
      lat = (b == 32'd0) ? 3 : 34;
      @(negedge clk);
      op1 = a; op2 = b; signed_div = s; start = 1'b1; annul = 1'b0;
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (ready) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: ready never rose within %0d edges, expected at %0d", name, n, lat);
      end else if (n != lat) begin
         errors++;
         $display("FAIL %s_latency: ready after %0d edges, expected %0d", name, n, lat);
      end
      if (chk_lit) pin({name, "_result"}, result, lit);
      $display("div %s: op1=%h op2=%h signed=%0d -> result=%h edges=%0d", name, a, b, s, result, n);
      @(posedge clk); #1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      pin({name, "_release"}, {63'd0, ready} | result, 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
      repeat (2) @(posedge clk);
      #1;
      pin("reset_ready", {63'd0, ready}, 64'd0);
      pin("reset_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      pin("model_divu_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'h2, 32'hE});
      pin("model_div_m100_7", ref_div(32'hFFFFFF9C, 32'd7, 1'b1), {32'hFFFFFFFE, 32'hFFFFFFF2});
      pin("model_div_100_m7", ref_div(32'd100, 32'hFFFFFFF9, 1'b1), {32'h2, 32'hFFFFFFF2});
      pin("model_div_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});

      run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1, {32'h2, 32'hE});
      run_div("div_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 1, {32'hFFFFFFFE, 32'hFFFFFFF2});
      run_div("div_100_m7", 32'd100, 32'hFFFFFFF9, 1'b1, 1, {32'h2, 32'hFFFFFFF2});
      run_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1, {32'h0, 32'h80000000});
      run_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 1, {32'h0, 32'hFFFFFFFF});
      run_div("div_by_zero", 32'd5, 32'd0, 1'b0, 1, 64'd0);

      // Annul at iteration 10, then an immediate fresh request.
      @(negedge clk);
      op1 = 32'd1000; op2 = 32'd7; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul = 1'b1;
      @(posedge clk); #1;
      pin("annul_ready", {63'd0, ready}, 64'd0);
      $display("annul at cnt=10: ready=%b result=%h", ready, result);
      run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 1, {32'h0, 32'h3});

      // Synchronous reset mid-iteration (cnt = 20).
      @(negedge clk);
      op1 = 32'd123456; op2 = 32'd789; signed_div = 1'b0; start = 1'b1;
      repeat (21) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      pin("midrst_outputs", {63'd0, ready} | result, 64'd0);
      $display("reset at cnt=20: ready=%b result=%h", ready, result);
      @(negedge clk);
      rst = 1'b0;
      run_div("after_reset", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 1, {32'hFFFFFFFE, 32'h0000000E});

      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = -32'($urandom_range(1, 15));
            3:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         run_div("random", a, b, s, 1, ref_div(a, b, s));
      end

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
